// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with hold timeout and one-cycle idle bubble.
// Shares one datapath resource; the grant vector is decoded from the registered owner index.
//
// decoder_2_to_4 ports:
//   in   [1:0]  index to decode
//   ena         enable; out is all zero when low
//   out  [3:0]  one-hot decode of in
//
// rr_arbiter_4 ports:
//   clk                 system clock, all state updates on posedge
//   rst                 synchronous active-low reset
//   req           [3:0] request vector, bit i = requester i wants the resource
//   release_grant       current owner is finished (ignored in IDLE)
//   grant         [3:0] one-hot grant, zero when no grant is active
//   grant_idx     [1:0] index of current/last owner
//   grant_valid         a grant is active
//   timeout             one-cycle pulse after a grant is revoked by MAX_HOLD

module decoder_2_to_4 (
    input  logic [1:0] in,
    input  logic       ena,
    output logic [3:0] out
);

    always_comb begin
        out = 4'b0000;
        if (ena) begin
            unique case (in)
                2'd0: out = 4'b0001;
                2'd1: out = 4'b0010;
                2'd2: out = 4'b0100;
                2'd3: out = 4'b1000;
            endcase
        end
    end

endmodule

module rr_arbiter_4 #(
    parameter int MAX_HOLD = 16,
    parameter int CW       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       release_grant,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Counter value seen on the last permitted BUSY cycle.
    localparam int            HOLD_LIM  = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_LIM);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [1:0]    last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;

    logic [1:0]    p1, p2, p3;
    logic [1:0]    winner;

    // Scan order starts just after the previous owner, so the previous
    // owner is checked last.
    assign p1 = last_q + 2'd1;
    assign p2 = last_q + 2'd2;
    assign p3 = last_q + 2'd3;

    always_comb begin
        winner = last_q;
        if (req[p1]) begin
            winner = p1;
        end else if (req[p2]) begin
            winner = p2;
        end else if (req[p3]) begin
            winner = p3;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    idx_d   = winner;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                if (release_grant || !req[idx_q]) begin
                    last_d  = idx_q;
                    state_d = IDLE;
                end else if (MAX_HOLD != 0 && cnt_q == HOLD_LAST) begin
                    last_d  = idx_q;
                    state_d = IDLE;
                    to_d    = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            last_q  <= 2'd3;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    assign grant_idx   = idx_q;
    assign grant_valid = (state_q == BUSY);
    assign timeout     = to_q;

    decoder_2_to_4 u_dec (
        .in  (idx_q),
        .ena (grant_valid),
        .out (grant)
    );

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4 (MAX_HOLD=4).
// Directed scenarios plus a randomized run against a behavioural model.

module tb_rr_arbiter_4;

    localparam int MH = 4;

    typedef struct packed {
        logic [3:0] g;
        logic       v;
        logic       t;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       rel;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int checks   = 0;
    int failures = 0;
    exp_t sb[$];

    rr_arbiter_4 #(.MAX_HOLD(MH), .CW(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .release_grant (rel),
        .grant         (grant),
        .grant_idx     (grant_idx),
        .grant_valid   (grant_valid),
        .timeout       (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b0;
        req = 4'b1111;
        rel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(exp_t'{4'b0000, 1'b0, 1'b0});
            step();
            e = sb.pop_front();
            checks++;
            if ({grant, grant_valid, timeout} !== e) begin
                failures++;
                $display("FAIL reset[%0d] got=%b want=%b", i,
                         {grant, grant_valid, timeout}, e);
            end
        end
        rst = 1'b1;
        sb.push_back(exp_t'{4'b0001, 1'b1, 1'b0});
        step();
        e = sb.pop_front();
        checks++;
        if ({grant, grant_valid, timeout} !== e || grant_idx !== 2'd0) begin
            failures++;
            $display("FAIL reset_first got=%b idx=%0d want=%b idx=0",
                     {grant, grant_valid, timeout}, grant_idx, e);
        end
    endtask

    task automatic test_rotation();
        exp_t e;
        logic [3:0] eg [8];
        eg = '{4'b0000, 4'b0010, 4'b0000, 4'b0100,
               4'b0000, 4'b1000, 4'b0000, 4'b0001};
        for (int i = 0; i < 8; i++) begin
            req = 4'b1111;
            rel = (i % 2 == 0);
            sb.push_back(exp_t'{eg[i], |eg[i], 1'b0});
            step();
            e = sb.pop_front();
            checks++;
            if ({grant, grant_valid, timeout} !== e) begin
                failures++;
                $display("FAIL rotation[%0d] got=%b want=%b", i,
                         {grant, grant_valid, timeout}, e);
            end
        end
    endtask

    task automatic test_skip_wrap();
        exp_t e;
        logic [3:0] rq [8];
        logic       rl [8];
        logic [3:0] eg [8];
        rq = '{4'b1111, 4'b0010, 4'b0010, 4'b0001,
               4'b0001, 4'b0011, 4'b0000, 4'b0000};
        rl = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        eg = '{4'b0000, 4'b0010, 4'b0000, 4'b0001,
               4'b0000, 4'b0010, 4'b0000, 4'b0000};
        for (int i = 0; i < 8; i++) begin
            req = rq[i];
            rel = rl[i];
            sb.push_back(exp_t'{eg[i], |eg[i], 1'b0});
            step();
            e = sb.pop_front();
            checks++;
            if ({grant, grant_valid, timeout} !== e) begin
                failures++;
                $display("FAIL skip_wrap[%0d] got=%b want=%b", i,
                         {grant, grant_valid, timeout}, e);
            end
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        logic [3:0] rq [7];
        logic [3:0] eg [7];
        logic       et [7];
        rq = '{4'b0100, 4'b0100, 4'b0100, 4'b0100,
               4'b0100, 4'b0100, 4'b0000};
        eg = '{4'b0100, 4'b0100, 4'b0100, 4'b0100,
               4'b0000, 4'b0100, 4'b0000};
        et = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            req = rq[i];
            rel = 1'b0;
            sb.push_back(exp_t'{eg[i], |eg[i], et[i]});
            step();
            e = sb.pop_front();
            checks++;
            if ({grant, grant_valid, timeout} !== e) begin
                failures++;
                $display("FAIL timeout[%0d] got=%b want=%b", i,
                         {grant, grant_valid, timeout}, e);
            end
        end
    endtask

    task automatic test_coincide();
        exp_t e;
        logic [3:0] rq [6];
        logic       rl [6];
        logic [3:0] eg [6];
        rq = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
        rl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        eg = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            req = rq[i];
            rel = rl[i];
            sb.push_back(exp_t'{eg[i], |eg[i], 1'b0});
            step();
            e = sb.pop_front();
            checks++;
            if ({grant, grant_valid, timeout} !== e) begin
                failures++;
                $display("FAIL coincide[%0d] got=%b want=%b", i,
                         {grant, grant_valid, timeout}, e);
            end
        end
    endtask

    task automatic test_abandon();
        exp_t e;
        logic [3:0] rq [4];
        logic       rl [4];
        logic [3:0] eg [4];
        rq = '{4'b0100, 4'b1011, 4'b1011, 4'b0000};
        rl = '{1'b0, 1'b0, 1'b0, 1'b1};
        eg = '{4'b0100, 4'b0000, 4'b1000, 4'b0000};
        for (int i = 0; i < 4; i++) begin
            req = rq[i];
            rel = rl[i];
            sb.push_back(exp_t'{eg[i], |eg[i], 1'b0});
            step();
            e = sb.pop_front();
            checks++;
            if ({grant, grant_valid, timeout} !== e) begin
                failures++;
                $display("FAIL abandon[%0d] got=%b want=%b", i,
                         {grant, grant_valid, timeout}, e);
            end
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        logic [3:0] rq [5];
        logic       rl [5];
        logic       rs [5];
        logic [3:0] eg [5];
        rq = '{4'b0100, 4'b0100, 4'b1000, 4'b1001, 4'b1001};
        rl = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        rs = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        eg = '{4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            req = rq[i];
            rel = rl[i];
            rst = rs[i];
            sb.push_back(exp_t'{eg[i], |eg[i], 1'b0});
            step();
            e = sb.pop_front();
            checks++;
            if ({grant, grant_valid, timeout} !== e) begin
                failures++;
                $display("FAIL mid_reset[%0d] got=%b want=%b", i,
                         {grant, grant_valid, timeout}, e);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_random();
        exp_t       e;
        logic       m_busy;
        logic [1:0] m_idx;
        logic [1:0] m_last;
        int         m_cnt;
        logic       m_to;
        int         wait_cnt [4];
        logic       was_valid;
        logic [3:0] r;
        logic       rv;
        logic       found;
        logic [1:0] p;

        rst = 1'b0;
        req = 4'b0000;
        rel = 1'b0;
        step();
        rst = 1'b1;
        m_busy = 1'b0;
        m_idx = 2'd0;
        m_last = 2'd3;
        m_cnt = 0;
        m_to = 1'b0;
        was_valid = 1'b0;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;

        for (int c = 0; c < 1000; c++) begin
            for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 9) < 8);
            rv = ($urandom_range(0, 3) == 0);
            req = r;
            rel = rv;
            for (int i = 0; i < 4; i++) if (!r[i]) wait_cnt[i] = 0;

            m_to = 1'b0;
            if (!m_busy) begin
                found = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    p = m_last + 2'(k);
                    if (!found && r[p]) begin
                        found = 1'b1;
                        m_idx = p;
                    end
                end
                if (found) begin
                    m_busy = 1'b1;
                    m_cnt = 0;
                end
            end else if (rv || !r[m_idx]) begin
                m_busy = 1'b0;
                m_last = m_idx;
            end else if (m_cnt == MH - 1) begin
                m_busy = 1'b0;
                m_last = m_idx;
                m_to = 1'b1;
            end else begin
                m_cnt++;
            end

            sb.push_back(exp_t'{(m_busy ? 4'(4'b0001 << m_idx) : 4'b0000),
                                m_busy, m_to});
            step();
            e = sb.pop_front();

            checks++;
            if ({grant, grant_valid, timeout} !== e ||
                (m_busy && grant_idx !== m_idx)) begin
                failures++;
                $display("FAIL random[%0d] got=%b idx=%0d want=%b idx=%0d",
                         c, {grant, grant_valid, timeout}, grant_idx,
                         e, m_idx);
            end

            checks++;
            if ($countones(grant) > 1 ||
                ((grant != 4'b0000) !== grant_valid) ||
                (grant_valid && grant !== 4'(4'b0001 << grant_idx))) begin
                failures++;
                $display("FAIL invariant[%0d] grant=%b valid=%b idx=%0d",
                         c, grant, grant_valid, grant_idx);
            end

            if (grant_valid && !was_valid) begin
                for (int i = 0; i < 4; i++) begin
                    if (i == int'(grant_idx)) begin
                        wait_cnt[i] = 0;
                    end else if (r[i]) begin
                        wait_cnt[i]++;
                        checks++;
                        if (wait_cnt[i] > 3) begin
                            failures++;
                            $display("FAIL starve[%0d] req%0d waited=%0d max=3",
                                     c, i, wait_cnt[i]);
                        end
                    end
                end
            end
            was_valid = grant_valid;
        end
        req = 4'b0000;
        rel = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        req = 4'b0000;
        rel = 1'b0;
        test_reset();
        test_rotation();
        test_skip_wrap();
        test_timeout();
        test_coincide();
        test_abandon();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
